prefetch_queue: RTL and testbench
=================================

// Module: prefetch_queue
// PURPOSE
// Parametrised instruction prefetch queue for the NEC core family. Sits between the
// bus control unit and the pre-decoder/execute loop. It fetches code bytes from
// PS:PFP via a req/ack port and exposes a PEEK-byte lookahead window. It handles
// variable consume, flush-on-branch, misaligned fetch starts and 8/16/32-bit buses.
// PARAMETERS
// DEPTH      8  queue capacity in bytes; power of 2, >= 2*BUS_BYTES
// BUS_BYTES  2  bytes per fetch beat (1, 2 or 4); fetch_addr is aligned to this
// PEEK       3  bytes visible at the head window (q0..q[PEEK-1]); PEEK <= DEPTH
// PORTS
// clk          in   1              core clock
// reset        in   1              synchronous, active-high
// ce           in   1              clock enable; no state changes when low
// flush        in   1              discard queue, restart fetch at flush_pc
// flush_pc     in   16             new PFP offset within PS
// consume      in   $clog2(PEEK+1) bytes retired from head this ce (0..PEEK)
// q_bytes      out  PEEK*8         head window; byte i = bits [8i+7:8i]
// q_len        out  $clog2(DEPTH+1) valid bytes in queue
// fetch_req    out  1              level request for one fetch beat
// fetch_addr   out  16             aligned PS offset of the requested beat
// fetch_ack    in   1              one-ce pulse: fetch_data valid, beat complete
// fetch_data   in   BUS_BYTES*8    beat data, little-endian
// BEHAVIOUR
// - Reset: q_len=0, fetch_req=0, fetch_addr=0, pfp=0, discard=0; q_bytes=0.
//   The first ce after reset raises fetch_req at fetch_addr=0.
// - State: circular byte RAM, head/tail ptrs mod DEPTH, pfp (16b), req_out, discard flag.
// - fetch_req is raised when !req_out and free space (DEPTH-q_len) >= BUS_BYTES.
//   Once raised, it is held with fetch_addr stable until fetch_ack. Exactly one
//   beat is outstanding at a time.
// - fetch_addr = pfp & ~(BUS_BYTES-1). On ack, skip = pfp mod BUS_BYTES.
//   Write bytes [skip..BUS_BYTES-1] at tail; pfp += BUS_BYTES-skip (16-bit wrap,
//   0xFFFF->0x0000).
// - Only the first beat after a flush to an odd or unaligned pc can have skip != 0.
// - consume: head += consume, q_len -= consume.
//   consume > q_len is a caller error: assert in sim, clamp to q_len in RTL.
// - Same-ce consume + ack: both apply; q_len' = q_len - consume + accepted.
//   The free-space test uses pre-consume q_len (no bypass).
// - flush (priority over consume and ack in same ce):
//   head=tail, q_len=0, pfp=flush_pc.
//   If req_out, set discard; the in-flight beat's ack is dropped and req_out
//   clears. The next request issues the following ce.
//   If !req_out, a request at the new pc issues the next ce.
// - flush while discard already set: update pfp only; still one beat dropped.
// - q_bytes/q_len are registered. Bytes beyond q_len in the window read 0.
//   Ack data is visible the ce after ack (1-ce fill latency).
// - ack with !req_out is ignored. BCU shares the reset, so no stale ack crosses reset.
// - Reset mid-beat: all state returns to reset values. Outstanding beat abandoned.
// STRUCTURE
// - Shared package (types): pq_beat_t struct {addr, data, skip}; PFP_W=16 constant.
// - One sub-module: pq_ram, a DEPTH x 8 circular store with BUS_BYTES write ports
//   (masked) and PEEK read ports at head. The rest is control in prefetch_queue.
// TESTING
// 1 Reset, BUS_BYTES=2; ack beats AA55,1234 -> q_len 4, q_bytes={12,34,AA,55}? no: q0=55,q1=AA,q2=34.
// 2 flush_pc=0x0101 -> fetch_addr=0x0100. Ack data=BBCC -> q_len=1, q0=BB.
//   Next fetch_addr=0x0102.
// 3 Fill to DEPTH=8 -> fetch_req stays 0. consume=2 -> fetch_req rises next ce.
// 4 Same-ce consume=3 and ack (2 bytes) at q_len=5 -> q_len=4; head data in order.
// 5 flush during outstanding beat -> ack dropped, q_len stays 0.
//   Next fetch_addr = flush_pc aligned. A double flush drops one beat only.
// 6 pfp=0xFFFE, BUS_BYTES=4, two beats -> addrs 0xFFFC then 0x0000. Wrap ok; q_len=6.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
//   PFP_W          width of the prefetch pointer / PS offset
//   MAX_BUS_BYTES  widest fetch beat supported (32-bit bus)
//   pq_beat_t      one fetch beat as seen by the control path: the aligned
//                  request address, the raw beat data (zero-extended to the
//                  widest bus) and the number of leading bytes to drop
//   align_down     clears the low address bits below a bus-width boundary
package prefetch_queue_pkg;

    localparam int PFP_W         = 16;
    localparam int MAX_BUS_BYTES = 4;

    typedef struct packed {
        logic [PFP_W-1:0]           addr;
        logic [MAX_BUS_BYTES*8-1:0] data;
        logic [1:0]                 skip;
    } pq_beat_t;

    function automatic logic [PFP_W-1:0] align_down(input logic [PFP_W-1:0] a,
                                                    input int              bus_bytes);
        return a & ~PFP_W'(bus_bytes - 1);
    endfunction

endpackage

// File: rtl/pq_ram.sv
// Circular byte store for the prefetch queue.
//   clk       core clock
//   wr_base   tail pointer; write port k lands at wr_base+k (mod DEPTH)
//   wr_mask   per-port write enable, one bit per beat byte
//   wr_data   beat bytes already shifted so port k carries byte k
//   rd_base   head pointer; read port i returns byte at rd_base+i (mod DEPTH)
//   rd_data   PEEK bytes starting at the head, byte i = bits [8i+7:8i]
module pq_ram #(
    parameter int DEPTH     = 8,
    parameter int BUS_BYTES = 2,
    parameter int PEEK      = 3
) (
    input  logic                       clk,
    input  logic [$clog2(DEPTH)-1:0]   wr_base,
    input  logic [BUS_BYTES-1:0]       wr_mask,
    input  logic [BUS_BYTES*8-1:0]     wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_base,
    output logic [PEEK*8-1:0]          rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];

    // NOTE: the byte store has no reset; every byte is written before the
    // occupancy count lets it reach the outputs, so its power-up value is never seen.
    always_ff @(posedge clk) begin
        for (int k = 0; k < BUS_BYTES; k++) begin
            if (wr_mask[k]) begin
                mem[wr_base + PTR_W'(k)] <= wr_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PEEK; i++) begin
            rd_data[8*i +: 8] = mem[rd_base + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue between the bus control unit and the pre-decoder.
// Fetches code bytes at PS:PFP one beat at a time and presents a PEEK-byte
// lookahead window at the head.
//   clk, reset   core clock, synchronous active-high reset
//   ce           clock enable; nothing changes while low
//   flush        drop the queue and restart fetching at flush_pc
//   flush_pc     new prefetch offset within PS
//   consume      bytes retired from the head this ce (0..PEEK)
//   q_bytes      head window, byte i = bits [8i+7:8i]; bytes past q_len read 0
//   q_len        number of valid bytes queued
//   fetch_req    level request for one beat, held until fetch_ack
//   fetch_addr   bus-aligned PS offset of the requested beat
//   fetch_ack    one-ce pulse completing the outstanding beat
//   fetch_data   beat data, little-endian
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BUS_BYTES = 2,
    parameter int PEEK      = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         flush,
    input  logic [PFP_W-1:0]             flush_pc,
    input  logic [$clog2(PEEK+1)-1:0]    consume,
    output logic [PEEK*8-1:0]            q_bytes,
    output logic [$clog2(DEPTH+1)-1:0]   q_len,
    output logic                         fetch_req,
    output logic [PFP_W-1:0]             fetch_addr,
    input  logic                         fetch_ack,
    input  logic [BUS_BYTES*8-1:0]       fetch_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] head, tail;
    logic [LEN_W-1:0] len;
    logic [PFP_W-1:0] pfp;
    logic [PFP_W-1:0] req_addr;
    logic             req_out;
    logic             discard;

    pq_beat_t               beat;
    logic [LEN_W-1:0]       consumed;
    logic [LEN_W-1:0]       accepted;
    logic                   take_beat;
    logic                   raise_req;
    logic [BUS_BYTES-1:0]   wr_mask;
    logic [BUS_BYTES*8-1:0] wr_data;
    logic [PEEK*8-1:0]      rd_data;

    // NOTE: every signal written here gets a value before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        beat      = '0;
        beat.addr = req_addr;
        beat.data = 32'(fetch_data);
        // pfp only moves on an accepted beat or a flush, so it still holds the
        // request's start offset when the ack arrives.
        beat.skip = 2'(pfp & PFP_W'(BUS_BYTES - 1));

        consumed  = (LEN_W'(consume) > len) ? len : LEN_W'(consume);
        accepted  = LEN_W'(BUS_BYTES) - LEN_W'(beat.skip);
        take_beat = ce && !flush && fetch_ack && req_out && !discard;
        // Free space is judged on the pre-consume length.
        raise_req = !req_out && ((LEN_W'(DEPTH) - len) >= LEN_W'(BUS_BYTES));

        wr_data   = (BUS_BYTES*8)'(beat.data >> {beat.skip, 3'b000});
        for (int k = 0; k < BUS_BYTES; k++) begin
            wr_mask[k] = take_beat && (LEN_W'(k) < accepted);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            len      <= '0;
            pfp      <= '0;
            req_addr <= '0;
            req_out  <= 1'b0;
            discard  <= 1'b0;
        end else if (ce) begin
            if (flush) begin
                head <= tail;
                len  <= '0;
                pfp  <= flush_pc;
                if (req_out && fetch_ack) begin
                    // The in-flight beat completes in the flush ce itself:
                    // drop it here rather than marking a later beat for discard.
                    req_out <= 1'b0;
                    discard <= 1'b0;
                end else if (req_out) begin
                    discard <= 1'b1;
                end
            end else begin
                head <= head + PTR_W'(consumed);
                len  <= len - consumed + (take_beat ? accepted : LEN_W'(0));
                if (req_out && fetch_ack) begin
                    req_out <= 1'b0;
                    discard <= 1'b0;
                    if (!discard) begin
                        tail <= tail + PTR_W'(accepted);
                        pfp  <= pfp + PFP_W'(accepted);
                    end
                end else if (raise_req) begin
                    req_out  <= 1'b1;
                    req_addr <= align_down(pfp, BUS_BYTES);
                end
            end
        end
    end

    pq_ram #(
        .DEPTH     (DEPTH),
        .BUS_BYTES (BUS_BYTES),
        .PEEK      (PEEK)
    ) u_pq_ram (
        .clk     (clk),
        .wr_base (tail),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .rd_base (head),
        .rd_data (rd_data)
    );

    always_comb begin
        for (int i = 0; i < PEEK; i++) begin
            q_bytes[8*i +: 8] = (LEN_W'(i) < len) ? rd_data[8*i +: 8] : 8'h00;
        end
    end

    assign q_len      = len;
    assign fetch_req  = req_out;
    assign fetch_addr = beat.addr;

    // Retiring more bytes than are queued is a caller error; the datapath clamps it.
    consume_in_range: assert property (@(posedge clk) disable iff (reset)
        (ce && !flush) |-> (LEN_W'(consume) <= len));

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic on a 16-bit
// bus instance, compared each cycle against a byte-queue reference model; a
// second 32-bit bus instance covers the pointer wrap at the top of PS.
module tb_prefetch_queue;

    localparam int DEPTH = 8;
    localparam int PEEK  = 3;
    localparam int BB    = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit bus instance
    logic        reset, ce, flush, fetch_ack, fetch_req;
    logic [15:0] flush_pc, fetch_addr, fetch_data;
    logic [1:0]  consume;
    logic [23:0] q_bytes;
    logic [3:0]  q_len;

    // 32-bit bus instance
    logic        reset_4, ce_4, flush_4, fetch_ack_4, fetch_req_4;
    logic [15:0] flush_pc_4, fetch_addr_4;
    logic [31:0] fetch_data_4;
    logic [1:0]  consume_4;
    logic [23:0] q_bytes_4;
    logic [3:0]  q_len_4;

    prefetch_queue #(.DEPTH(DEPTH), .BUS_BYTES(BB), .PEEK(PEEK)) dut (
        .clk(clk), .reset(reset), .ce(ce), .flush(flush), .flush_pc(flush_pc),
        .consume(consume), .q_bytes(q_bytes), .q_len(q_len), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data)
    );

    prefetch_queue #(.DEPTH(DEPTH), .BUS_BYTES(4), .PEEK(PEEK)) dut_4 (
        .clk(clk), .reset(reset_4), .ce(ce_4), .flush(flush_4), .flush_pc(flush_pc_4),
        .consume(consume_4), .q_bytes(q_bytes_4), .q_len(q_len_4), .fetch_req(fetch_req_4),
        .fetch_addr(fetch_addr_4), .fetch_ack(fetch_ack_4), .fetch_data(fetch_data_4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: queued bytes in order, prefetch pointer, outstanding request.
    logic [7:0]  mq[$];
    logic [15:0] m_pfp, m_addr;
    bit          m_req, m_drop;

    task automatic model_reset();
        mq.delete();
        m_pfp = 16'h0; m_addr = 16'h0; m_req = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit c, input bit f, input logic [15:0] pc,
                              input int cons, input bit a, input logic [15:0] d);
        int free;
        int skip;
        if (rst) begin
            model_reset();
            return;
        end
        if (!c) return;
        if (f) begin
            mq.delete();
            m_pfp = pc;
            if (m_req && a) begin
                m_req = 1'b0; m_drop = 1'b0;
            end else if (m_req) begin
                m_drop = 1'b1;
            end
            return;
        end
        free = DEPTH - mq.size();
        for (int i = 0; i < cons; i++) mq.delete(0);
        if (m_req && a) begin
            m_req = 1'b0;
            if (m_drop) begin
                m_drop = 1'b0;
            end else begin
                skip = int'(m_pfp) % BB;
                for (int b = skip; b < BB; b++) mq.push_back(d[8*b +: 8]);
                m_pfp = 16'(int'(m_pfp) + BB - skip);
            end
        end else if (!m_req && free >= BB) begin
            m_req  = 1'b1;
            m_addr = 16'(int'(m_pfp) - int'(m_pfp) % BB);
        end
    endtask

    function automatic logic [23:0] model_window();
        logic [23:0] w = '0;
        for (int i = 0; i < PEEK; i++) begin
            if (i < mq.size()) w[8*i +: 8] = mq[i];
        end
        return w;
    endfunction

    task automatic compare_all();
        check("q_len", 32'(q_len), 32'(mq.size()));
        check("fetch_req", 32'(fetch_req), 32'(m_req));
        if (m_req) check("fetch_addr", 32'(fetch_addr), 32'(m_addr));
        check("q_bytes", 32'(q_bytes), 32'(model_window()));
    endtask

    // One ce of the 16-bit instance: drive, advance the model, sample at the next negedge.
    task automatic tick(input bit rst, input bit c, input bit f, input logic [15:0] pc,
                        input int cons, input bit a, input logic [15:0] d);
        reset = rst; ce = c; flush = f; flush_pc = pc;
        consume = 2'(cons); fetch_ack = a; fetch_data = d;
        model_step(rst, c, f, pc, cons, a, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        tick(1'b0, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
    endtask

    task automatic ack(input logic [15:0] d, input int cons);
        tick(1'b0, 1'b1, 1'b0, 16'h0, cons, 1'b1, d);
    endtask

    task automatic do_flush(input logic [15:0] pc);
        tick(1'b0, 1'b1, 1'b1, pc, 0, 1'b0, 16'h0);
    endtask

    task automatic tick_4(input bit f, input logic [15:0] pc, input bit a, input logic [31:0] d);
        reset_4 = 1'b0; ce_4 = 1'b1; flush_4 = f; flush_pc_4 = pc;
        consume_4 = 2'd0; fetch_ack_4 = a; fetch_data_4 = d;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; flush = 1'b0; flush_pc = '0; consume = '0;
        fetch_ack = 1'b0; fetch_data = '0;
        reset_4 = 1'b1; ce_4 = 1'b0; flush_4 = 1'b0; flush_pc_4 = '0; consume_4 = '0;
        fetch_ack_4 = 1'b0; fetch_data_4 = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_q_len", 32'(q_len), 32'd0);
        check("rst_fetch_req", 32'(fetch_req), 32'd0);
        check("rst_fetch_addr", 32'(fetch_addr), 32'd0);
        check("rst_q_bytes", 32'(q_bytes), 32'd0);

        // Pointer wrap on a 32-bit bus: 0xFFFE -> beats at 0xFFFC then 0x0000
        tick_4(1'b1, 16'hFFFE, 1'b0, 32'h0);
        tick_4(1'b0, 16'h0, 1'b0, 32'h0);
        check("w4_req", 32'(fetch_req_4), 32'd1);
        check("w4_addr0", 32'(fetch_addr_4), 32'h0000FFFC);
        tick_4(1'b0, 16'h0, 1'b1, 32'h44332211);
        check("w4_len_first", 32'(q_len_4), 32'd2);
        tick_4(1'b0, 16'h0, 1'b0, 32'h0);
        check("w4_addr1", 32'(fetch_addr_4), 32'h00000000);
        tick_4(1'b0, 16'h0, 1'b1, 32'h88776655);
        check("w4_len", 32'(q_len_4), 32'd6);
        check("w4_bytes", 32'(q_bytes_4), 32'h00554433);
        ce_4 = 1'b0; fetch_ack_4 = 1'b0;

        // Two beats after reset
        tick(1'b0, 1'b1, 1'b0, 16'h0, 0, 1'b0, 16'h0);
        check("t1_req", 32'(fetch_req), 32'd1);
        check("t1_addr", 32'(fetch_addr), 32'd0);
        ack(16'hAA55, 0);
        idle();
        ack(16'h1234, 0);
        check("t1_len", 32'(q_len), 32'd4);
        check("t1_bytes", 32'(q_bytes), 32'h0034AA55);

        // Flush to an odd pc: first beat keeps only its upper byte
        do_flush(16'h0101);
        idle();
        check("t2_addr", 32'(fetch_addr), 32'h0100);
        ack(16'hBBCC, 0);
        check("t2_len", 32'(q_len), 32'd1);
        check("t2_bytes", 32'(q_bytes), 32'h000000BB);
        idle();
        check("t2_next_addr", 32'(fetch_addr), 32'h0102);

        // Fill to capacity, then drain two bytes
        ack(16'h0201, 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            ack(16'(16'h1111 * (i + 3)), 0);
        end
        idle();
        check("t3_full_len", 32'(q_len), 32'd8);
        check("t3_full_req", 32'(fetch_req), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 16'h0, 2, 1'b0, 16'h0);
        check("t3_consume_req", 32'(fetch_req), 32'd0);
        idle();
        check("t3_req_rise", 32'(fetch_req), 32'd1);

        // Consume and ack in the same ce
        tick(1'b0, 1'b1, 1'b0, 16'h0, 1, 1'b0, 16'h0);
        check("t4_len5", 32'(q_len), 32'd5);
        ack(16'hDEAD, 3);
        check("t4_len", 32'(q_len), 32'd4);

        // Flush with a beat in flight, then a double flush
        idle();
        do_flush(16'h2345);
        check("t5_held_req", 32'(fetch_req), 32'd1);
        ack(16'hFFFF, 0);
        check("t5_drop_len", 32'(q_len), 32'd0);
        check("t5_drop_req", 32'(fetch_req), 32'd0);
        idle();
        check("t5_addr", 32'(fetch_addr), 32'h2344);
        do_flush(16'h3000);
        do_flush(16'h4001);
        ack(16'hEEEE, 0);
        check("t5_dbl_len", 32'(q_len), 32'd0);
        idle();
        check("t5_dbl_addr", 32'(fetch_addr), 32'h4000);
        ack(16'h7788, 0);
        check("t5_one_drop", 32'(q_len), 32'd1);
        check("t5_bytes", 32'(q_bytes), 32'h00000077);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst, r_ce, r_fl, r_ack;
            int          r_cons, lim;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_ce   = r_rst || ($urandom_range(0, 9) != 0);
            r_fl   = ($urandom_range(0, 19) == 0);
            lim    = (mq.size() < PEEK) ? mq.size() : PEEK;
            r_cons = $urandom_range(0, lim);
            r_ack  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            tick(r_rst, r_ce, r_fl, 16'($urandom), r_cons, r_ack, 16'($urandom));
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0, 0, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
